// File: rtl/his_reader_fsm_pkg.sv
// Shared defaults and state encoding for the histogram readout engine.
package his_reader_fsm_pkg;

    localparam int unsigned NbDefault       = 8;
    localparam int unsigned CntWDefault     = 10;
    localparam int unsigned PixelNumDefault = 200;
    localparam int unsigned PixWDefault     = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StLat,
        StOut,
        StPeak
    } state_e;

endpackage

// File: rtl/his_reader_fsm_if.sv
// Valid/ready stream carrying one histogram bin count with its pixel/bin tags.
interface his_reader_fsm_if
    import his_reader_fsm_pkg::*;
#(
    parameter int unsigned Nb   = NbDefault,
    parameter int unsigned CntW = CntWDefault,
    parameter int unsigned PixW = PixWDefault
) ();

    logic            valid;
    logic            ready;
    logic [PixW-1:0] pixel;
    logic [Nb-1:0]   bin;
    logic [CntW-1:0] count;
    logic            last_bin;
    logic            last;

    modport master (
        output valid, pixel, bin, count, last_bin, last,
        input  ready
    );

    modport slave (
        input  valid, pixel, bin, count, last_bin, last,
        output ready
    );

endinterface

// File: rtl/his_reader_fsm_peak_tracker.sv
// Running per-pixel maximum; strict compare keeps the lowest bin on ties.
module his_peak_tracker
    import his_reader_fsm_pkg::*;
#(
    parameter int unsigned Nb   = NbDefault,
    parameter int unsigned CntW = CntWDefault
) (
    input  logic            clk_i,
    input  logic            res_ni,
    input  logic            clr_i,
    input  logic            upd_i,
    input  logic [Nb-1:0]   bin_i,
    input  logic [CntW-1:0] count_i,
    output logic [Nb-1:0]   max_bin_o,
    output logic [CntW-1:0] max_count_o
);

    logic [Nb-1:0]   max_bin_q, max_bin_d;
    logic [CntW-1:0] max_count_q, max_count_d;

    always_ff @(posedge clk_i) begin
        if (!res_ni) begin
            max_bin_q   <= '0;
            max_count_q <= '0;
        end else begin
            max_bin_q   <= max_bin_d;
            max_count_q <= max_count_d;
        end
    end

    always_comb begin
        max_bin_d   = max_bin_q;
        max_count_d = max_count_q;
        if (clr_i) begin
            max_bin_d   = '0;
            max_count_d = '0;
        end else if (upd_i && (count_i > max_count_q)) begin
            max_bin_d   = bin_i;
            max_count_d = count_i;
        end
    end

    assign max_bin_o   = max_bin_q;
    assign max_count_o = max_count_q;

endmodule

// File: rtl/his_reader_fsm.sv
// Walks every {pixel, bin} of a finished histogram bank: read, clear, stream out,
// then report each pixel's peak bin.
module his_reader_fsm
    import his_reader_fsm_pkg::*;
#(
    parameter int unsigned Nb       = NbDefault,
    parameter int unsigned CntW     = CntWDefault,
    parameter int unsigned PixelNum = PixelNumDefault,
    parameter int unsigned PixW     = PixWDefault
) (
    input  logic               clk_i,
    input  logic               res_ni,
    input  logic               start_i,
    input  logic               bank_i,
    output logic               busy_o,
    output logic               overrun_o,
    output logic               ram_rd_en_o,
    output logic               ram_bank_o,
    output logic [PixW+Nb-1:0] ram_addr_o,
    input  logic [CntW-1:0]    ram_rd_data_i,
    output logic               ram_clr_en_o,
    his_reader_fsm_if.master   out_if,
    output logic               peak_valid_o,
    output logic [PixW-1:0]    peak_pixel_o,
    output logic [Nb-1:0]      peak_bin_o,
    output logic [CntW-1:0]    peak_count_o,
    output logic               done_o
);

    localparam logic [Nb-1:0]   LastBin   = '1;
    localparam logic [PixW-1:0] LastPixel = PixW'(PixelNum - 1);

    state_e          state_q, state_d;
    logic            bank_q, bank_d;
    logic [PixW-1:0] pixel_q, pixel_d;
    logic [Nb-1:0]   bin_q, bin_d;
    logic [CntW-1:0] count_q, count_d;
    logic            trk_clr, trk_upd;

    always_ff @(posedge clk_i) begin
        if (!res_ni) begin
            state_q <= StIdle;
            bank_q  <= 1'b0;
            pixel_q <= '0;
            bin_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            pixel_q <= pixel_d;
            bin_q   <= bin_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        pixel_d = pixel_q;
        bin_d   = bin_q;
        count_d = count_q;
        trk_clr = 1'b0;
        trk_upd = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    bank_d  = bank_i;
                    pixel_d = '0;
                    bin_d   = '0;
                    trk_clr = 1'b1;
                    state_d = StRd;
                end
            end
            StRd: state_d = StLat;
            StLat: begin
                // Read data arrives now; the clear strobe hits the same address this cycle.
                count_d = ram_rd_data_i;
                trk_upd = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                if (out_if.ready) begin
                    if (bin_q != LastBin) begin
                        bin_d   = bin_q + Nb'(1);
                        state_d = StRd;
                    end else begin
                        state_d = StPeak;
                    end
                end
            end
            StPeak: begin
                if (pixel_q != LastPixel) begin
                    pixel_d = pixel_q + PixW'(1);
                    bin_d   = '0;
                    trk_clr = 1'b1;
                    state_d = StRd;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    his_peak_tracker #(
        .Nb   (Nb),
        .CntW (CntW)
    ) u_peak_tracker (
        .clk_i       (clk_i),
        .res_ni      (res_ni),
        .clr_i       (trk_clr),
        .upd_i       (trk_upd),
        .bin_i       (bin_q),
        .count_i     (ram_rd_data_i),
        .max_bin_o   (peak_bin_o),
        .max_count_o (peak_count_o)
    );

    assign busy_o       = (state_q != StIdle);
    assign overrun_o    = start_i && (state_q != StIdle);
    assign ram_rd_en_o  = (state_q == StRd);
    assign ram_clr_en_o = (state_q == StLat);
    assign ram_bank_o   = bank_q;
    assign ram_addr_o   = {pixel_q, bin_q};

    assign out_if.valid    = (state_q == StOut);
    assign out_if.pixel    = pixel_q;
    assign out_if.bin      = bin_q;
    assign out_if.count    = count_q;
    assign out_if.last_bin = (bin_q == LastBin);
    assign out_if.last     = (bin_q == LastBin) && (pixel_q == LastPixel);

    assign peak_valid_o = (state_q == StPeak);
    assign peak_pixel_o = pixel_q;
    assign done_o       = (state_q == StPeak) && (pixel_q == LastPixel);

endmodule

// File: tb/tb_his_reader_fsm.sv
// Random-fill bench for his_reader_fsm: RAM model plus an array-based expected stream.
module tb_his_reader_fsm;

    localparam int unsigned Nb       = 2;
    localparam int unsigned CntW     = 10;
    localparam int unsigned PixelNum = 3;
    localparam int unsigned PixW     = 2;
    localparam int          Bins     = 1 << Nb;
    localparam int          Total    = PixelNum * Bins;
    localparam int          Depth    = 1 << (PixW + Nb);
    localparam int          PerPixel = 3 * Bins + 1;
    localparam int          Budget   = 3000;

    logic               clk = 1'b0;
    logic               res_n = 1'b0;
    logic               start = 1'b0;
    logic               bank = 1'b0;
    logic               load = 1'b0;
    logic               busy, overrun, ram_rd_en, ram_bank, ram_clr_en;
    logic [PixW+Nb-1:0] ram_addr;
    logic [CntW-1:0]    ram_rd_data;
    logic               peak_valid, done;
    logic [PixW-1:0]    peak_pixel;
    logic [Nb-1:0]      peak_bin;
    logic [CntW-1:0]    peak_count;

    logic [CntW-1:0] img [2][Depth];
    logic [CntW-1:0] mem [2][Depth];

    int n_chk  = 0;
    int n_pass = 0;

    his_reader_fsm_if #(.Nb(Nb), .CntW(CntW), .PixW(PixW)) out_if ();

    his_reader_fsm #(
        .Nb       (Nb),
        .CntW     (CntW),
        .PixelNum (PixelNum),
        .PixW     (PixW)
    ) dut (
        .clk_i         (clk),
        .res_ni        (res_n),
        .start_i       (start),
        .bank_i        (bank),
        .busy_o        (busy),
        .overrun_o     (overrun),
        .ram_rd_en_o   (ram_rd_en),
        .ram_bank_o    (ram_bank),
        .ram_addr_o    (ram_addr),
        .ram_rd_data_i (ram_rd_data),
        .ram_clr_en_o  (ram_clr_en),
        .out_if        (out_if),
        .peak_valid_o  (peak_valid),
        .peak_pixel_o  (peak_pixel),
        .peak_bin_o    (peak_bin),
        .peak_count_o  (peak_count),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    // Histogram RAM: one-cycle read latency, write-zero on clear.
    always @(posedge clk) begin
        if (load) begin
            mem <= img;
        end else begin
            if (ram_rd_en) ram_rd_data <= mem[ram_bank][ram_addr];
            if (ram_clr_en) mem[ram_bank][ram_addr] <= '0;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".rd_en"}, int'(ram_rd_en), 0);
        check({tag, ".clr_en"}, int'(ram_clr_en), 0);
        check({tag, ".valid"}, int'(out_if.valid), 0);
        check({tag, ".peak_valid"}, int'(peak_valid), 0);
        check({tag, ".done"}, int'(done), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_quiet(tag);
        check({tag, ".overrun"}, int'(overrun), 0);
        check({tag, ".bank"}, int'(ram_bank), 0);
        check({tag, ".addr"}, int'(ram_addr), 0);
        check({tag, ".count"}, int'(out_if.count), 0);
        check({tag, ".pixel"}, int'(out_if.pixel), 0);
        check({tag, ".bin"}, int'(out_if.bin), 0);
        check({tag, ".last"}, int'(out_if.last), 0);
        check({tag, ".last_bin"}, int'(out_if.last_bin), 0);
        check({tag, ".peak_pixel"}, int'(peak_pixel), 0);
        check({tag, ".peak_bin"}, int'(peak_bin), 0);
        check({tag, ".peak_count"}, int'(peak_count), 0);
    endtask

    // Peak = maximum count of the pixel, reported at the lowest bin holding it.
    function automatic void exp_peak(input int b, input int p, output int pbin, output int pcnt);
        int m;
        m = 0;
        for (int i = 0; i < Bins; i++) if (int'(img[b][p*Bins+i]) > m) m = int'(img[b][p*Bins+i]);
        pbin = 0;
        for (int i = Bins - 1; i >= 0; i--) if (int'(img[b][p*Bins+i]) == m) pbin = i;
        pcnt = m;
    endfunction

    task automatic fill_random(input int b);
        for (int a = 0; a < Depth; a++) begin
            case ($urandom_range(0, 3))
                0:       img[b][a] = '0;
                1:       img[b][a] = '1;
                2:       img[b][a] = CntW'($urandom_range(0, 3));
                default: img[b][a] = CntW'($urandom_range(0, 1023));
            endcase
        end
    endtask

    task automatic load_mem();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_readout(input int bnk, input int ready_pct, input int ov_at,
                               input bit do_reset);
        int idx, pk, cyc, pbin, pcnt, bad;
        bit fin, aborted, prev_stall;
        idx = 0; pk = 0; cyc = 0; fin = 0; aborted = 0; prev_stall = 0;
        @(negedge clk);
        bank = bnk[0];
        start = 1'b1;
        out_if.ready = ($urandom_range(0, 99) < ready_pct);
        #1;
        check("idle.busy", int'(busy), 0);
        check("idle.overrun", int'(overrun), 0);
        while (!fin && !aborted && cyc < Budget) begin
            @(negedge clk);
            cyc++;
            start = (cyc == ov_at);
            out_if.ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            check("overrun", int'(overrun), int'(start));
            check("busy", int'(busy), 1);
            if (ram_rd_en) check("rd_bank", int'(ram_bank), bnk);
            if (ram_clr_en) check("clr_bank", int'(ram_bank), bnk);
            if (prev_stall) check("valid_hold", int'(out_if.valid), 1);
            prev_stall = out_if.valid && !out_if.ready;
            if (out_if.valid) begin
                if (idx < Total) begin
                    check("pixel", int'(out_if.pixel), idx / Bins);
                    check("bin", int'(out_if.bin), idx % Bins);
                    check("count", int'(out_if.count), int'(img[bnk][idx]));
                    check("last_bin", int'(out_if.last_bin), int'((idx % Bins) == Bins - 1));
                    check("last", int'(out_if.last), int'(idx == Total - 1));
                end else begin
                    check("extra_xfer", idx, Total - 1);
                end
                if (do_reset && out_if.pixel == 1 && out_if.bin == 2) aborted = 1;
                else if (out_if.ready) idx++;
            end
            if (!aborted) begin
                check("done", int'(done), int'(peak_valid && pk == PixelNum - 1));
                if (peak_valid) begin
                    exp_peak(bnk, pk, pbin, pcnt);
                    check("peak_after_last_bin", idx, (pk + 1) * Bins);
                    check("peak_pixel", int'(peak_pixel), pk);
                    check("peak_bin", int'(peak_bin), pbin);
                    check("peak_count", int'(peak_count), pcnt);
                    pk++;
                end
                if (done) fin = 1;
            end
        end
        if (aborted) begin
            res_n = 1'b0;
            start = 1'b0;
            @(negedge clk);
            #1;
            check_reset_outputs("mid_reset");
            res_n = 1'b1;
        end else begin
            check("finished_in_budget", int'(fin), 1);
            if (ready_pct >= 100) check("done_cycle", cyc, PixelNum * PerPixel);
            check("xfer_total", idx, Total);
            check("peak_total", pk, PixelNum);
            @(negedge clk);
            start = 1'b0;
            #1;
            check_quiet("after_done");
            bad = 0;
            for (int a = 0; a < Total; a++) if (mem[bnk][a] != '0) bad++;
            check("bins_cleared", bad, 0);
            bad = 0;
            for (int a = 0; a < Depth; a++) if (mem[1-bnk][a] != img[1-bnk][a]) bad++;
            check("other_bank_intact", bad, 0);
        end
    endtask

    initial begin
        out_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        res_n = 1'b1;

        // Directed fill: ties, an all-zero pixel, and saturated counts.
        fill_random(1);
        for (int a = 0; a < Depth; a++) img[0][a] = '0;
        img[0][0] = 10'd3; img[0][1] = 10'd7; img[0][2] = 10'd7; img[0][3] = 10'd1;
        img[0][8] = 10'd1023; img[0][9] = 10'd5; img[0][10] = 10'd1023; img[0][11] = 10'd0;
        load_mem();
        run_readout(0, 100, -1, 0);
        load_mem();
        run_readout(0, 33, -1, 0);

        fill_random(0);
        fill_random(1);
        load_mem();
        run_readout(1, 50, -1, 0);

        load_mem();
        run_readout(0, 100, 5, 0);
        load_mem();
        run_readout(1, 100, PixelNum * PerPixel, 0);

        load_mem();
        run_readout(0, 70, -1, 1);
        load_mem();
        run_readout(0, 60, -1, 0);

        for (int k = 0; k < 4; k++) begin
            fill_random(0);
            fill_random(1);
            load_mem();
            run_readout(k % 2, int'($urandom_range(20, 100)), -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
